// File: rtl/bcd2binary_if.sv
// bcd2binary_if: start/busy/done handshake and data bus for bcd2binary.
// The master requests conversions; the slave is the converter.
interface bcd2binary_if #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );
endinterface

// File: rtl/bcd2binary.sv
// bcd2binary: sequential packed-BCD to unsigned binary converter.
// Reverse double-dabble: shift right, then -3 on every BCD nibble >= 8.
module bcd2binary #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    bcd2binary_if.slave bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [BIN_W-1:0]  bin_q, bin_d;

    logic [WORK_W-1:0] shifted;
    logic [WORK_W-1:0] adjusted;
    logic              bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign shifted = work_q >> 1;

    // A nibble is >= 8 exactly when its top bit is set.
    always_comb begin
        adjusted = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i + 3]) begin
                adjusted[BIN_W + 4*i +: 4] =
                    shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bin_d   = bin_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bad_digit) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                work_d = adjusted;
                cnt_d  = cnt_q + CNT_W'(1);
                // Final step: result is the post-shift value.
                if (cnt_q == LAST) begin
                    bin_d   = shifted[BIN_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;
endmodule
